// File: rtl/ctrl_pkg.sv
// Shared widths and bit positions of the EX/M/WB control groups produced by the ID-stage decoder.
package ctrl_pkg;

    localparam int EX_W = 3;
    localparam int M_W  = 3;
    localparam int WB_W = 2;

    localparam int EX_REGDST   = 2;
    localparam int EX_ALUOP    = 1;
    localparam int EX_ALUSRC   = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-pipe bus: decoder bundles and ALU flag in, staged controls, hazard flags and counters out.
// The master side drives the decoder inputs and observes everything else; values are level signals sampled each clock.
interface ctrl_pipe_if
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);

    logic [EX_W-1:0]   ex_in;
    logic [M_W-1:0]    m_in;
    logic [WB_W-1:0]   wb_in;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              alu_zero;

    logic              ex_reg_dst;
    logic              ex_alu_op;
    logic              ex_alu_src;
    logic [REG_AW-1:0] ex_dst;
    logic              mem_branch;
    logic              mem_read;
    logic              mem_write;
    logic [REG_AW-1:0] mem_dst;
    logic              branch_taken;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_dst;
    logic              stall;
    logic              flush_ifid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output ex_in, m_in, wb_in, id_rs, id_rt, id_rd, alu_zero,
        input  ex_reg_dst, ex_alu_op, ex_alu_src, ex_dst,
        input  mem_branch, mem_read, mem_write, mem_dst, branch_taken,
        input  wb_reg_write, wb_mem_to_reg, wb_dst,
        input  stall, flush_ifid, stall_cnt, flush_cnt
    );

    modport slave (
        input  ex_in, m_in, wb_in, id_rs, id_rt, id_rd, alu_zero,
        output ex_reg_dst, ex_alu_op, ex_alu_src, ex_dst,
        output mem_branch, mem_read, mem_write, mem_dst, branch_taken,
        output wb_reg_write, wb_mem_to_reg, wb_dst,
        output stall, flush_ifid, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline-register slot: loads d_i each cycle, or zeros (a bubble) on rst or clr_i.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            data_q <= '0;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoder control bundles through ID/EX, EX/MEM and MEM/WB, inserting bubbles for
// load-use hazards and taken branches, and counts stall and flush cycles with saturation.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 16,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    ctrl_pipe_if.slave  bus
);

    localparam int IDEX_W  = EX_W + M_W + WB_W + 2 * REG_AW;
    localparam int EXMEM_W = M_W + WB_W + REG_AW + 1;
    localparam int MEMWB_W = WB_W + REG_AW;

    logic [IDEX_W-1:0]  idex_d, idex_q;
    logic [EXMEM_W-1:0] exmem_d, exmem_q;
    logic [MEMWB_W-1:0] memwb_d, memwb_q;

    logic [EX_W-1:0]   idex_ex;
    logic [M_W-1:0]    idex_m;
    logic [WB_W-1:0]   idex_wb;
    logic [REG_AW-1:0] idex_rt, idex_rd, ex_dst_w;

    logic [M_W-1:0]    exmem_m;
    logic [WB_W-1:0]   exmem_wb;
    logic [REG_AW-1:0] exmem_dst;
    logic              exmem_zero;

    logic [WB_W-1:0]   memwb_wb;
    logic [REG_AW-1:0] memwb_dst;

    logic hazard, branch_taken, stall;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    assign {idex_ex, idex_m, idex_wb, idex_rt, idex_rd} = idex_q;
    assign {exmem_m, exmem_wb, exmem_dst, exmem_zero}   = exmem_q;
    assign {memwb_wb, memwb_dst}                        = memwb_q;

    assign ex_dst_w = idex_ex[EX_REGDST] ? idex_rd : idex_rt;

    // A load in EX whose target is read by the instruction in ID; $zero never creates a dependency.
    assign hazard = HAZARD_EN && idex_m[M_MEMREAD] && (idex_rt != '0) &&
                    ((idex_rt == bus.id_rs) || (idex_rt == bus.id_rt));
    assign branch_taken = exmem_m[M_BRANCH] & exmem_zero;
    assign stall        = hazard & ~branch_taken;

    assign idex_d  = {bus.ex_in, bus.m_in, bus.wb_in, bus.id_rt, bus.id_rd};
    assign exmem_d = {idex_m, idex_wb, ex_dst_w, bus.alu_zero};
    assign memwb_d = {exmem_wb, exmem_dst};

    ctrl_stage_reg #(.W(IDEX_W)) u_idex (
        .clk   (clk),
        .rst   (rst),
        .clr_i (hazard | branch_taken),
        .d_i   (idex_d),
        .q_o   (idex_q)
    );

    ctrl_stage_reg #(.W(EXMEM_W)) u_exmem (
        .clk   (clk),
        .rst   (rst),
        .clr_i (branch_taken),
        .d_i   (exmem_d),
        .q_o   (exmem_q)
    );

    ctrl_stage_reg #(.W(MEMWB_W)) u_memwb (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .d_i   (memwb_d),
        .q_o   (memwb_q)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.ex_reg_dst    = idex_ex[EX_REGDST];
    assign bus.ex_alu_op     = idex_ex[EX_ALUOP];
    assign bus.ex_alu_src    = idex_ex[EX_ALUSRC];
    assign bus.ex_dst        = ex_dst_w;
    assign bus.mem_branch    = exmem_m[M_BRANCH];
    assign bus.mem_read      = exmem_m[M_MEMREAD];
    assign bus.mem_write     = exmem_m[M_MEMWRITE];
    assign bus.mem_dst       = exmem_dst;
    assign bus.branch_taken  = branch_taken;
    assign bus.wb_reg_write  = memwb_wb[WB_REGWRITE];
    assign bus.wb_mem_to_reg = memwb_wb[WB_MEMTOREG];
    assign bus.wb_dst        = memwb_dst;
    assign bus.stall         = stall;
    assign bus.flush_ifid    = branch_taken;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: three instances (default, 2-bit counters, hazard detection off) share one
// stimulus stream and are compared every cycle against a stage-by-stage behavioural model.
module tb_ctrl_pipe;

    logic       clk;
    logic       rst;
    logic [2:0] ex_in, m_in;
    logic [1:0] wb_in;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       alu_zero;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_AW(5), .CNT_W(16)) bus0 ();
    ctrl_pipe_if #(.REG_AW(5), .CNT_W(2))  bus1 ();
    ctrl_pipe_if #(.REG_AW(5), .CNT_W(16)) bus2 ();

    ctrl_pipe #(.REG_AW(5), .CNT_W(16), .HAZARD_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    ctrl_pipe #(.REG_AW(5), .CNT_W(2),  .HAZARD_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ctrl_pipe #(.REG_AW(5), .CNT_W(16), .HAZARD_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    assign bus0.ex_in = ex_in;  assign bus1.ex_in = ex_in;  assign bus2.ex_in = ex_in;
    assign bus0.m_in = m_in;    assign bus1.m_in = m_in;    assign bus2.m_in = m_in;
    assign bus0.wb_in = wb_in;  assign bus1.wb_in = wb_in;  assign bus2.wb_in = wb_in;
    assign bus0.id_rs = id_rs;  assign bus1.id_rs = id_rs;  assign bus2.id_rs = id_rs;
    assign bus0.id_rt = id_rt;  assign bus1.id_rt = id_rt;  assign bus2.id_rt = id_rt;
    assign bus0.id_rd = id_rd;  assign bus1.id_rd = id_rd;  assign bus2.id_rd = id_rd;
    assign bus0.alu_zero = alu_zero; assign bus1.alu_zero = alu_zero; assign bus2.alu_zero = alu_zero;

    // Observed output groups per instance, zero-extended to 32 bits.
    logic [31:0] o_ex[3], o_mem[3], o_wb[3], o_hz[3], o_sc[3], o_fc[3];

    assign o_ex[0]  = 32'({bus0.ex_reg_dst, bus0.ex_alu_op, bus0.ex_alu_src, bus0.ex_dst});
    assign o_mem[0] = 32'({bus0.mem_branch, bus0.mem_read, bus0.mem_write, bus0.mem_dst});
    assign o_wb[0]  = 32'({bus0.wb_reg_write, bus0.wb_mem_to_reg, bus0.wb_dst});
    assign o_hz[0]  = 32'({bus0.stall, bus0.flush_ifid, bus0.branch_taken});
    assign o_sc[0]  = 32'(bus0.stall_cnt);
    assign o_fc[0]  = 32'(bus0.flush_cnt);
    assign o_ex[1]  = 32'({bus1.ex_reg_dst, bus1.ex_alu_op, bus1.ex_alu_src, bus1.ex_dst});
    assign o_mem[1] = 32'({bus1.mem_branch, bus1.mem_read, bus1.mem_write, bus1.mem_dst});
    assign o_wb[1]  = 32'({bus1.wb_reg_write, bus1.wb_mem_to_reg, bus1.wb_dst});
    assign o_hz[1]  = 32'({bus1.stall, bus1.flush_ifid, bus1.branch_taken});
    assign o_sc[1]  = 32'(bus1.stall_cnt);
    assign o_fc[1]  = 32'(bus1.flush_cnt);
    assign o_ex[2]  = 32'({bus2.ex_reg_dst, bus2.ex_alu_op, bus2.ex_alu_src, bus2.ex_dst});
    assign o_mem[2] = 32'({bus2.mem_branch, bus2.mem_read, bus2.mem_write, bus2.mem_dst});
    assign o_wb[2]  = 32'({bus2.wb_reg_write, bus2.wb_mem_to_reg, bus2.wb_dst});
    assign o_hz[2]  = 32'({bus2.stall, bus2.flush_ifid, bus2.branch_taken});
    assign o_sc[2]  = 32'(bus2.stall_cnt);
    assign o_fc[2]  = 32'(bus2.flush_cnt);

    // Reference model: what each pipeline slot currently holds, by named field.
    typedef struct packed {
        logic reg_dst, alu_op, alu_src, branch, mem_read, mem_write, reg_write, mem_to_reg;
        logic [4:0] rt, rd;
    } id_ex_t;
    typedef struct packed {
        logic branch, mem_read, mem_write, reg_write, mem_to_reg, zero;
        logic [4:0] dst;
    } ex_mem_t;
    typedef struct packed {
        logic reg_write, mem_to_reg;
        logic [4:0] dst;
    } mem_wb_t;

    id_ex_t      m_ie[3];
    ex_mem_t     m_xm[3];
    mem_wb_t     m_mw[3];
    int unsigned m_sc[3], m_fc[3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_ie[k] = '0; m_xm[k] = '0; m_mw[k] = '0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    // Check current outputs of instance k against the model, then advance the model by one edge.
    task automatic model_step(input int k);
        int unsigned cmax;
        logic        hen, taken, hz, stl;
        logic [4:0]  edst;
        id_ex_t      ie;
        ex_mem_t     xm;
        mem_wb_t     mw;
        cmax  = (k == 1) ? 3 : 65535;
        hen   = (k != 2);
        ie    = m_ie[k]; xm = m_xm[k]; mw = m_mw[k];
        taken = xm.branch && xm.zero;
        hz    = hen && ie.mem_read && (ie.rt != 0) && (ie.rt == id_rs || ie.rt == id_rt);
        stl   = hz && !taken;
        edst  = ie.reg_dst ? ie.rd : ie.rt;

        check_val($sformatf("d%0d.ex", k),  o_ex[k],  32'({ie.reg_dst, ie.alu_op, ie.alu_src, edst}));
        check_val($sformatf("d%0d.mem", k), o_mem[k], 32'({xm.branch, xm.mem_read, xm.mem_write, xm.dst}));
        check_val($sformatf("d%0d.wb", k),  o_wb[k],  32'({mw.reg_write, mw.mem_to_reg, mw.dst}));
        check_val($sformatf("d%0d.hz", k),  o_hz[k],  32'({stl, taken, taken}));
        check_val($sformatf("d%0d.scnt", k), o_sc[k], m_sc[k]);
        check_val($sformatf("d%0d.fcnt", k), o_fc[k], m_fc[k]);

        if (rst) begin
            m_ie[k] = '0; m_xm[k] = '0; m_mw[k] = '0; m_sc[k] = 0; m_fc[k] = 0;
        end else begin
            m_mw[k] = '{reg_write: xm.reg_write, mem_to_reg: xm.mem_to_reg, dst: xm.dst};
            if (taken) m_xm[k] = '0;
            else m_xm[k] = '{branch: ie.branch, mem_read: ie.mem_read, mem_write: ie.mem_write,
                             reg_write: ie.reg_write, mem_to_reg: ie.mem_to_reg,
                             zero: alu_zero, dst: edst};
            if (taken || hz) m_ie[k] = '0;
            else m_ie[k] = '{reg_dst: ex_in[2], alu_op: ex_in[1], alu_src: ex_in[0],
                             branch: m_in[2], mem_read: m_in[1], mem_write: m_in[0],
                             reg_write: wb_in[1], mem_to_reg: wb_in[0], rt: id_rt, rd: id_rd};
            if (stl && m_sc[k] < cmax) m_sc[k]++;
            if (taken && m_fc[k] < cmax) m_fc[k]++;
        end
    endtask

    task automatic step(input logic r, input logic [2:0] e, input logic [2:0] m, input logic [1:0] w,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic z);
        @(negedge clk);
        rst = r; ex_in = e; m_in = m; wb_in = w; id_rs = rs; id_rt = rt; id_rd = rd; alu_zero = z;
        #1;
        for (int k = 0; k < 3; k++) model_step(k);
    endtask

    task automatic nop(input logic z);
        step(1'b0, 3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, z);
    endtask

    task automatic rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic z);
        step(1'b0, 3'b110, 3'b000, 2'b10, rs, rt, rd, z);
    endtask

    task automatic lw(input logic [4:0] rs, input logic [4:0] rt, input logic z);
        step(1'b0, 3'b001, 3'b010, 2'b11, rs, rt, 5'd0, z);
    endtask

    task automatic beq(input logic [4:0] rs, input logic [4:0] rt, input logic z);
        step(1'b0, 3'b010, 3'b100, 2'b00, rs, rt, 5'd0, z);
    endtask

    initial begin
        rst = 1'b1; ex_in = '0; m_in = '0; wb_in = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        step(1'b1, 3'b000, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0);

        // R-type through all three stages.
        rtype(5'd1, 5'd2, 5'd5, 1'b0);
        repeat (3) nop(1'b0);

        // Load-use on rt=8 (add re-presented after the stall), then the same with rt=0.
        lw(5'd3, 5'd8, 1'b0);
        rtype(5'd8, 5'd9, 5'd10, 1'b0);
        rtype(5'd8, 5'd9, 5'd10, 1'b0);
        lw(5'd3, 5'd0, 1'b0);
        rtype(5'd0, 5'd0, 5'd11, 1'b0);
        repeat (3) nop(1'b0);

        // Taken beq (zero while it is in EX), then not-taken.
        beq(5'd1, 5'd2, 1'b0);
        rtype(5'd4, 5'd5, 5'd6, 1'b1);
        rtype(5'd4, 5'd5, 5'd7, 1'b0);
        rtype(5'd4, 5'd5, 5'd12, 1'b0);
        repeat (3) nop(1'b0);
        beq(5'd1, 5'd2, 1'b0);
        rtype(5'd4, 5'd5, 5'd6, 1'b0);
        repeat (3) nop(1'b0);

        // Load-use in the same cycle as a taken branch.
        beq(5'd1, 5'd2, 1'b0);
        lw(5'd3, 5'd8, 1'b1);
        rtype(5'd8, 5'd1, 5'd13, 1'b0);
        repeat (3) nop(1'b0);

        // Reset with all three stages full.
        rtype(5'd1, 5'd2, 5'd3, 1'b0);
        lw(5'd1, 5'd4, 1'b0);
        beq(5'd6, 5'd7, 1'b0);
        step(1'b1, 3'b110, 3'b000, 2'b10, 5'd4, 5'd2, 5'd9, 1'b1);
        nop(1'b0);
        check_val("rst.scnt", o_sc[0], 32'd0);
        check_val("rst.fcnt", o_fc[0], 32'd0);
        check_val("rst.wb",   o_wb[0], 32'd0);
        check_val("rst.ex",   o_ex[0], 32'd0);

        // Five load-use stalls: 2-bit counter saturates at 3, hazard-disabled instance never stalls.
        for (int i = 0; i < 5; i++) begin
            lw(5'd2, 5'd8, 1'b0);
            rtype(5'd8, 5'd3, 5'd4, 1'b0);
            rtype(5'd8, 5'd3, 5'd4, 1'b0);
        end
        nop(1'b0);
        check_val("sat.d0", o_sc[0], 32'd5);
        check_val("sat.d1", o_sc[1], 32'd3);
        check_val("sat.d2", o_sc[2], 32'd0);

        // Random instruction mix over a small register set so hazards and branches are frequent.
        for (int i = 0; i < 800; i++) begin
            logic [4:0] rs, rt, rd;
            logic       z, r;
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            z  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 5))
                0: step(r, 3'b000, 3'b000, 2'b00, rs, rt, rd, z);
                1: step(r, 3'b110, 3'b000, 2'b10, rs, rt, rd, z);
                2: step(r, 3'b001, 3'b010, 2'b11, rs, rt, rd, z);
                3: step(r, 3'b001, 3'b001, 2'b00, rs, rt, rd, z);
                4: step(r, 3'b010, 3'b100, 2'b00, rs, rt, rd, z);
                default: step(r, 3'($urandom), 3'($urandom), 2'($urandom), rs, rt, rd, z);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
